// File: rtl/alarma_defs.sv
// Shared definitions for the car alarm controller: state codes and widths.
package alarma_defs;

  localparam int ESTADO_W = 3;

  localparam logic [ESTADO_W-1:0] COD_DESARMADA  = 3'd0;
  localparam logic [ESTADO_W-1:0] COD_ARMANDO    = 3'd1;
  localparam logic [ESTADO_W-1:0] COD_VIGILANCIA = 3'd2;
  localparam logic [ESTADO_W-1:0] COD_PREALARMA  = 3'd3;
  localparam logic [ESTADO_W-1:0] COD_SIRENA     = 3'd4;
  localparam logic [ESTADO_W-1:0] COD_BLOQUEO    = 3'd5;

  typedef enum logic [ESTADO_W-1:0] {
    DESARMADA  = COD_DESARMADA,
    ARMANDO    = COD_ARMANDO,
    VIGILANCIA = COD_VIGILANCIA,
    PREALARMA  = COD_PREALARMA,
    SIRENA     = COD_SIRENA,
    BLOQUEO    = COD_BLOQUEO
  } estado_t;

endpackage

// File: rtl/alarma_cond.sv
// Combinational trigger rules: decides from the car sensors whether the alarm should fire.
module alarma_cond (
  input  logic p1,
  input  logic p2,
  input  logic t,
  input  logic m,
  input  logic f,
  output logic disparo
);

  logic w_p;

  assign w_p = p1 | p2;

  // Trunk opened with doors shut (engine either way), or engine on with a door open and no handbrake.
  assign disparo = (~w_p & ~t & m) | (t & ~w_p & m) | (~f & t & w_p);

endmodule

// File: rtl/alarma_ctrl.sv
// Car alarm sequencer: exit delay, entry delay, timed siren and lock-out after N_MAX activations.
module alarma_ctrl
  import alarma_defs::*;
#(
  parameter int T_SALIDA  = 8,
  parameter int T_ENTRADA = 6,
  parameter int T_SIRENA  = 10,
  parameter int N_MAX     = 3,
  parameter int W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c,
  input  logic                p1,
  input  logic                p2,
  input  logic                t,
  input  logic                m,
  input  logic                f,
  output logic                a,
  output logic                armada,
  output logic [ESTADO_W-1:0] estado,
  output logic [1:0]          n_disp
);

  localparam logic [W-1:0] CARGA_SALIDA  = W'(T_SALIDA - 1);
  localparam logic [W-1:0] CARGA_ENTRADA = W'(T_ENTRADA - 1);
  localparam logic [W-1:0] CARGA_SIRENA  = W'(T_SIRENA - 1);
  localparam logic [1:0]   N_MAX_C       = 2'(N_MAX);

  estado_t      r_state, w_state_nxt;
  logic [W-1:0] r_timer, w_timer_nxt, w_timer_dec;
  logic [1:0]   r_n_disp, w_n_disp_nxt;
  logic         w_disparo;

  alarma_cond u_cond (
    .p1      (p1),
    .p2      (p2),
    .t       (t),
    .m       (m),
    .f       (f),
    .disparo (w_disparo)
  );

  // Down-counter holds at zero instead of wrapping.
  assign w_timer_dec = (r_timer != '0) ? r_timer - 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= DESARMADA;
      r_timer  <= '0;
      r_n_disp <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_n_disp <= w_n_disp_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_n_disp_nxt = r_n_disp;
    if (!c) begin
      w_state_nxt  = DESARMADA;
      w_timer_nxt  = '0;
      w_n_disp_nxt = '0;
    end else begin
      case (r_state)
        DESARMADA: begin
          w_state_nxt = ARMANDO;
          w_timer_nxt = CARGA_SALIDA;
        end
        ARMANDO: begin
          w_timer_nxt = w_timer_dec;
          if (r_timer == '0) w_state_nxt = VIGILANCIA;
        end
        VIGILANCIA: begin
          if (w_disparo) begin
            if (r_n_disp < N_MAX_C) begin
              w_state_nxt = PREALARMA;
              w_timer_nxt = CARGA_ENTRADA;
            end else begin
              w_state_nxt = BLOQUEO;
            end
          end
        end
        PREALARMA: begin
          w_timer_nxt = w_timer_dec;
          if (r_timer == '0) begin
            w_state_nxt = SIRENA;
            w_timer_nxt = CARGA_SIRENA;
            if (r_n_disp < N_MAX_C) w_n_disp_nxt = r_n_disp + 1'b1;
          end
        end
        SIRENA: begin
          w_timer_nxt = w_timer_dec;
          if (r_timer == '0) w_state_nxt = VIGILANCIA;
        end
        BLOQUEO: w_state_nxt = BLOQUEO;
        default: begin
          w_state_nxt = DESARMADA;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  assign a      = (r_state == SIRENA);
  assign armada = (r_state == VIGILANCIA) || (r_state == PREALARMA) || (r_state == SIRENA);
  assign estado = r_state;
  assign n_disp = r_n_disp;

endmodule

// File: tb/tb_alarma_ctrl.sv
// Bench for alarma_ctrl: scripted vector table, two corner-case sequences and random traffic against a reference model.
module tb_alarma_ctrl;

  localparam int T_SALIDA  = 4;
  localparam int T_ENTRADA = 3;
  localparam int T_SIRENA  = 5;
  localparam int N_MAX     = 2;
  localparam int W         = 8;

  logic       clk = 1'b0;
  logic       reset, c, p1, p2, t, m, f;
  logic       a, armada;
  logic [2:0] estado;
  logic [1:0] n_disp;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number plus cycles still to spend in it.
  int m_st  = 0;
  int m_rem = 0;
  int m_n   = 0;

  typedef struct {
    logic       rst;
    logic       c;
    logic [4:0] sens;   // {p1,p2,t,m,f}
    int         est;
    logic       a;
    logic       arm;
    int         n;
  } vec_t;

  vec_t vq[$];

  alarma_ctrl #(
    .T_SALIDA (T_SALIDA),
    .T_ENTRADA(T_ENTRADA),
    .T_SIRENA (T_SIRENA),
    .N_MAX    (N_MAX),
    .W        (W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .c      (c),
    .p1     (p1),
    .p2     (p2),
    .t      (t),
    .m      (m),
    .f      (f),
    .a      (a),
    .armada (armada),
    .estado (estado),
    .n_disp (n_disp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit trig(input logic [4:0] s);
    bit dp1, dp2, dt, dm, df, door;
    {dp1, dp2, dt, dm, df} = s;
    door = dp1 || dp2;
    if (dm && !door) return 1'b1;        // trunk open, doors shut
    if (dt && door && !df) return 1'b1;  // engine on, door open, handbrake off
    return 1'b0;
  endfunction

  task automatic model_step(input logic rst, input logic cc, input logic [4:0] s);
    if (rst || !cc) begin
      m_st = 0; m_rem = 0; m_n = 0;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_rem = T_SALIDA; end
        1: if (m_rem <= 1) m_st = 2; else m_rem--;
        2: if (trig(s)) begin
             if (m_n < N_MAX) begin m_st = 3; m_rem = T_ENTRADA; end
             else m_st = 5;
           end
        3: if (m_rem <= 1) begin
             m_st = 4; m_rem = T_SIRENA;
             if (m_n < N_MAX) m_n++;
           end else m_rem--;
        4: if (m_rem <= 1) m_st = 2; else m_rem--;
        default: m_st = 5;
      endcase
    end
  endtask

  // Drive one cycle, advance the model, then compare DUT against the model.
  task automatic apply(input logic rst, input logic cc, input logic [4:0] s);
    reset = rst; c = cc;
    {p1, p2, t, m, f} = s;
    model_step(rst, cc, s);
    @(posedge clk);
    #1;
    chk("model_estado", int'(estado), m_st);
    chk("model_a", int'(a), (m_st == 4) ? 1 : 0);
    chk("model_armada", int'(armada), (m_st >= 2 && m_st <= 4) ? 1 : 0);
    chk("model_n_disp", int'(n_disp), m_n);
  endtask

  function automatic void add(input int rep, input logic rst, input logic cc, input logic [4:0] s,
                              input int est, input logic ea, input logic earm, input int en);
    vec_t v;
    v.rst = rst; v.c = cc; v.sens = s; v.est = est; v.a = ea; v.arm = earm; v.n = en;
    for (int i = 0; i < rep; i++) vq.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; c = 1'b0; p1 = 0; p2 = 0; t = 0; m = 0; f = 0;

    // Vector table: arming, one activation, ignored trigger while arming, lock-out.
    add(1, 1, 0, 5'b00000, 0, 0, 0, 0);
    add(4, 0, 1, 5'b00000, 1, 0, 0, 0);
    add(1, 0, 1, 5'b00000, 2, 0, 1, 0);
    add(1, 0, 1, 5'b00010, 3, 0, 1, 0);
    add(2, 0, 1, 5'b00000, 3, 0, 1, 0);
    add(5, 0, 1, 5'b00000, 4, 1, 1, 1);
    add(1, 0, 1, 5'b00000, 2, 0, 1, 1);
    add(1, 0, 0, 5'b00000, 0, 0, 0, 0);
    add(4, 0, 1, 5'b10100, 1, 0, 0, 0);
    add(1, 0, 1, 5'b10100, 2, 0, 1, 0);
    add(3, 0, 1, 5'b10100, 3, 0, 1, 0);
    add(5, 0, 1, 5'b10100, 4, 1, 1, 1);
    add(1, 0, 1, 5'b10100, 2, 0, 1, 1);
    add(3, 0, 1, 5'b10100, 3, 0, 1, 1);
    add(5, 0, 1, 5'b10100, 4, 1, 1, 2);
    add(1, 0, 1, 5'b10100, 2, 0, 1, 2);
    add(2, 0, 1, 5'b10100, 5, 0, 0, 2);
    add(1, 0, 0, 5'b10100, 0, 0, 0, 0);

    foreach (vq[i]) begin
      apply(vq[i].rst, vq[i].c, vq[i].sens);
      chk($sformatf("vec%0d_estado", i), int'(estado), vq[i].est);
      chk($sformatf("vec%0d_a", i), int'(a), int'(vq[i].a));
      chk($sformatf("vec%0d_armada", i), int'(armada), int'(vq[i].arm));
      chk($sformatf("vec%0d_n_disp", i), int'(n_disp), vq[i].n);
    end

    // c falling during SIRENA: disarm on the next edge, then a full exit delay again.
    repeat (5) apply(0, 1, 5'b00000);
    apply(0, 1, 5'b00010);
    repeat (4) apply(0, 1, 5'b00000);
    chk("sirena_before_disarm", int'(estado), 4);
    apply(0, 0, 5'b00000);
    chk("disarm_a", int'(a), 0);
    chk("disarm_estado", int'(estado), 0);
    apply(0, 1, 5'b00000);
    repeat (3) apply(0, 1, 5'b00000);
    chk("rearm_still_armando", int'(estado), 1);
    apply(0, 1, 5'b00000);
    chk("rearm_vigilancia", int'(estado), 2);

    // Reset during PREALARMA with c held high.
    apply(0, 1, 5'b00010);
    chk("pre_before_reset", int'(estado), 3);
    apply(1, 1, 5'b00000);
    chk("reset_estado", int'(estado), 0);
    chk("reset_a", int'(a), 0);
    chk("reset_armada", int'(armada), 0);
    chk("reset_n_disp", int'(n_disp), 0);
    apply(0, 1, 5'b00000);
    chk("after_reset_armando", int'(estado), 1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic       rr, cr;
      logic [4:0] sr;
      rr = (($urandom % 64) == 0);
      cr = (($urandom % 25) != 0);
      sr = 5'($urandom);
      apply(rr, cr, sr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
